// File: rtl/timer_irq_sequencer.sv
// Avalon-MM initiator that programs a 16-bit interval timer, then services and counts its timeout IRQs.
// Define TIMER_SNAPSHOT_EN to read back a counter snapshot after every serviced tick.
`timescale 1ns/1ps
module timer_irq_sequencer #(
    parameter int unsigned CNT_W     = 16,
    parameter logic [15:0] CTRL_RUN  = 16'h0007,
    parameter logic [15:0] CTRL_STOP = 16'h0008
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_start,
    input  logic             cfg_stop,
    input  logic [31:0]      cfg_period,
    output logic             busy,
    output logic             tick_pulse,
    output logic [CNT_W-1:0] tick_count,
    output logic [2:0]       tmr_address,
    output logic             tmr_chipselect,
    output logic             tmr_write_n,
    output logic [15:0]      tmr_writedata,
    input  logic [15:0]      tmr_readdata,
    input  logic             tmr_irq,
    output logic [31:0]      snap_value
);
    localparam int unsigned ADDR_W = 3;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned PER_W  = 32;

    localparam logic [ADDR_W-1:0] A_STATUS  = 3'd0;
    localparam logic [ADDR_W-1:0] A_CONTROL = 3'd1;
    localparam logic [ADDR_W-1:0] A_PERL    = 3'd2;
    localparam logic [ADDR_W-1:0] A_PERH    = 3'd3;
`ifdef TIMER_SNAPSHOT_EN
    localparam logic [ADDR_W-1:0] A_SNAPL   = 3'd4;
    localparam logic [ADDR_W-1:0] A_SNAPH   = 3'd5;
`endif

    typedef enum logic [3:0] {
        IDLE,
        WR_PL,
        WR_PH,
        WR_CTRL,
        WAIT_IRQ,
        CLR_ST,
        WR_STOP
`ifdef TIMER_SNAPSHOT_EN
        ,
        SNAP_WR,
        SNAP_RL,
        SNAP_RH,
        SNAP_CAP
`endif
    } state_e;

    state_e             state_q, state_d;
    logic [PER_W-1:0]   period_q, period_d;
    logic               stop_pend_q, stop_pend_d;
    logic [CNT_W-1:0]   tick_count_q, tick_count_d;
    logic               busy_q, busy_d;
    logic               tick_pulse_q, tick_pulse_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic               cs_q, cs_d;
    logic               wn_q, wn_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
`ifdef TIMER_SNAPSHOT_EN
    logic [PER_W-1:0]   snap_q, snap_d;
`endif

    // Next state, then registered bus/status outputs derived from the state being entered
    always_comb begin
        state_d      = state_q;
        period_d     = period_q;
        stop_pend_d  = stop_pend_q;
        tick_count_d = tick_count_q;
`ifdef TIMER_SNAPSHOT_EN
        snap_d       = snap_q;
`endif

        // A stop arriving mid-sequence is remembered and acted on back in WAIT_IRQ
        if (cfg_stop && state_q != IDLE && state_q != WAIT_IRQ && state_q != WR_STOP) begin
            stop_pend_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (cfg_start && !cfg_stop && cfg_period != 32'd0) begin
                    state_d      = WR_PL;
                    period_d     = cfg_period;
                    tick_count_d = '0;
                end
            end
            WR_PL:   state_d = WR_PH;
            WR_PH:   state_d = WR_CTRL;
            WR_CTRL: state_d = WAIT_IRQ;
            WAIT_IRQ: begin
                if (stop_pend_q || cfg_stop) begin
                    state_d = WR_STOP;
                end else if (tmr_irq) begin
                    state_d      = CLR_ST;
                    tick_count_d = tick_count_q + CNT_W'(1);
                end
            end
`ifdef TIMER_SNAPSHOT_EN
            CLR_ST:  state_d = SNAP_WR;
            SNAP_WR: state_d = SNAP_RL;
            SNAP_RL: state_d = SNAP_RH;
            SNAP_RH: begin
                state_d      = SNAP_CAP;
                snap_d[15:0] = tmr_readdata;
            end
            SNAP_CAP: begin
                state_d       = WAIT_IRQ;
                snap_d[31:16] = tmr_readdata;
            end
`else
            CLR_ST:  state_d = WAIT_IRQ;
`endif
            WR_STOP: begin
                state_d     = IDLE;
                stop_pend_d = 1'b0;
            end
            default: state_d = IDLE;
        endcase

        busy_d       = (state_d != IDLE);
        tick_pulse_d = (state_d == CLR_ST);
        cs_d         = 1'b0;
        wn_d         = 1'b1;
        addr_d       = '0;
        wdata_d      = '0;

        case (state_d)
            WR_PL: begin
                cs_d    = 1'b1;
                wn_d    = 1'b0;
                addr_d  = A_PERL;
                wdata_d = period_d[15:0];
            end
            WR_PH: begin
                cs_d    = 1'b1;
                wn_d    = 1'b0;
                addr_d  = A_PERH;
                wdata_d = period_d[31:16];
            end
            WR_CTRL: begin
                cs_d    = 1'b1;
                wn_d    = 1'b0;
                addr_d  = A_CONTROL;
                wdata_d = CTRL_RUN;
            end
            CLR_ST: begin
                cs_d    = 1'b1;
                wn_d    = 1'b0;
                addr_d  = A_STATUS;
                wdata_d = 16'h0000;
            end
            WR_STOP: begin
                cs_d    = 1'b1;
                wn_d    = 1'b0;
                addr_d  = A_CONTROL;
                wdata_d = CTRL_STOP;
            end
`ifdef TIMER_SNAPSHOT_EN
            SNAP_WR: begin
                cs_d    = 1'b1;
                wn_d    = 1'b0;
                addr_d  = A_SNAPL;
                wdata_d = 16'h0000;
            end
            SNAP_RL: begin
                cs_d    = 1'b1;
                addr_d  = A_SNAPL;
            end
            SNAP_RH: begin
                cs_d    = 1'b1;
                addr_d  = A_SNAPH;
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            period_q     <= '0;
            stop_pend_q  <= 1'b0;
            tick_count_q <= '0;
            busy_q       <= 1'b0;
            tick_pulse_q <= 1'b0;
            addr_q       <= '0;
            cs_q         <= 1'b0;
            wn_q         <= 1'b1;
            wdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            period_q     <= period_d;
            stop_pend_q  <= stop_pend_d;
            tick_count_q <= tick_count_d;
            busy_q       <= busy_d;
            tick_pulse_q <= tick_pulse_d;
            addr_q       <= addr_d;
            cs_q         <= cs_d;
            wn_q         <= wn_d;
            wdata_q      <= wdata_d;
        end
    end

`ifdef TIMER_SNAPSHOT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            snap_q <= '0;
        end else begin
            snap_q <= snap_d;
        end
    end

    assign snap_value = snap_q;
`else
    logic unused_readdata;
    assign unused_readdata = ^tmr_readdata;
    assign snap_value      = 32'd0;
`endif

    assign busy           = busy_q;
    assign tick_pulse     = tick_pulse_q;
    assign tick_count     = tick_count_q;
    assign tmr_address    = addr_q;
    assign tmr_chipselect = cs_q;
    assign tmr_write_n    = wn_q;
    assign tmr_writedata  = wdata_q;

endmodule
